// File: rtl/cpu_pc_pkg.sv
// Shared types and default vectors for the MIPS program-counter sequencer.
package cpu_pc_pkg;

  typedef enum logic [1:0] {
    PC_RUN   = 2'd0,
    PC_DELAY = 2'd1,
    PC_HALT  = 2'd2
  } pc_state_e;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'hBFC0_0380;
  localparam int          DEF_INSTR_BYTES  = 4;

endpackage

// File: rtl/cpu_pc_seq_if.sv
// Control-FSM <-> PC sequencer bundle; master is the control side.
interface cpu_pc_seq_if #(
  parameter int WIDTH = 32
);
  logic             advance;
  logic             branch_valid;
  logic [WIDTH-1:0] branch_target;
  logic             exc_req;
  logic [WIDTH-1:0] pc_o;
  logic             active_o;
  logic             in_delay_slot_o;
  logic [WIDTH-1:0] epc_o;
  logic             epc_bd_o;
  logic             misaligned_o;

  modport master (
    output advance, branch_valid, branch_target, exc_req,
    input  pc_o, active_o, in_delay_slot_o, epc_o, epc_bd_o, misaligned_o
  );

  modport slave (
    input  advance, branch_valid, branch_target, exc_req,
    output pc_o, active_o, in_delay_slot_o, epc_o, epc_bd_o, misaligned_o
  );
endinterface

// File: rtl/cpu_pc_seq.sv
// Program-counter sequencer: sequential fetch, optional branch delay slot,
// exception redirect with EPC/BD capture, and halt when the PC becomes zero.
//
// state    | meaning
// PC_RUN   | sequential execution
// PC_DELAY | pc_o is the delay-slot instruction; branch target held in target_q
// PC_HALT  | PC reached zero; frozen until reset
module cpu_pc_seq
  import cpu_pc_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEF_EXC_VECTOR),
  parameter int               INSTR_BYTES  = DEF_INSTR_BYTES,
  parameter int               DELAY_SLOTS  = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  cpu_pc_seq_if.slave       bus
);

  localparam logic [WIDTH-1:0] INC = WIDTH'(INSTR_BYTES);

  pc_state_e        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             epc_bd_q, epc_bd_d;
  logic             pc_load;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= PC_RUN;
      pc_q     <= RESET_VECTOR;
      target_q <= '0;
      epc_q    <= '0;
      epc_bd_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      target_q <= target_d;
      epc_q    <= epc_d;
      epc_bd_q <= epc_bd_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    target_d = target_q;
    epc_d    = epc_q;
    epc_bd_d = epc_bd_q;
    pc_load  = 1'b0;

    if (state_q != PC_HALT) begin
      if (bus.exc_req) begin
        pc_load  = 1'b1;
        pc_d     = EXC_VECTOR;
        state_d  = PC_RUN;
        target_d = '0;
        // In the slot, EPC points back at the branch so it re-executes.
        if (state_q == PC_DELAY) begin
          epc_d    = pc_q - INC;
          epc_bd_d = 1'b1;
        end else begin
          epc_d    = pc_q;
          epc_bd_d = 1'b0;
        end
      end else if (bus.advance) begin
        pc_load = 1'b1;
        if (state_q == PC_DELAY) begin
          pc_d    = target_q;
          state_d = PC_RUN;
        end else if (bus.branch_valid && (DELAY_SLOTS != 0)) begin
          target_d = bus.branch_target;
          pc_d     = pc_q + INC;
          state_d  = PC_DELAY;
        end else if (bus.branch_valid) begin
          pc_d = bus.branch_target;
        end else begin
          pc_d = pc_q + INC;
        end
      end

      if (pc_load && (pc_d == '0)) state_d = PC_HALT;
    end
  end

  assign bus.pc_o            = pc_q;
  assign bus.active_o        = (state_q != PC_HALT);
  assign bus.in_delay_slot_o = (state_q == PC_DELAY);
  assign bus.epc_o           = epc_q;
  assign bus.epc_bd_o        = epc_bd_q;
  assign bus.misaligned_o    = (pc_q[1:0] != 2'b00);

endmodule

// File: tb/tb_cpu_pc_seq.sv
// Scoreboard bench for cpu_pc_seq: delay-slot, no-delay-slot and 16-bit wrap configurations.
module tb_cpu_pc_seq;

  typedef struct {
    int          dut;
    logic [31:0] pc;
    logic        act;
    logic        ds;
    logic        mis;
    logic [31:0] epc;
    logic        bd;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  cpu_pc_seq_if #(.WIDTH(32)) ifa ();
  cpu_pc_seq_if #(.WIDTH(32)) ifb ();
  cpu_pc_seq_if #(.WIDTH(16)) ifc ();

  cpu_pc_seq #(.WIDTH(32), .DELAY_SLOTS(1)) dut_a (.clk(clk), .reset_n(reset_n), .bus(ifa));
  cpu_pc_seq #(.WIDTH(32), .DELAY_SLOTS(0)) dut_b (.clk(clk), .reset_n(reset_n), .bus(ifb));
  cpu_pc_seq #(.WIDTH(16), .RESET_VECTOR(16'hFFF8), .EXC_VECTOR(16'h0380),
               .DELAY_SLOTS(1)) dut_c (.clk(clk), .reset_n(reset_n), .bus(ifc));

  // Monitor: every expectation queued before a falling edge is checked on it.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      logic [31:0] pc, epc;
      logic act, ds, mis, bd;
      e = sb.pop_front();
      case (e.dut)
        0: begin pc = ifa.pc_o; act = ifa.active_o; ds = ifa.in_delay_slot_o;
                 mis = ifa.misaligned_o; epc = ifa.epc_o; bd = ifa.epc_bd_o; end
        1: begin pc = ifb.pc_o; act = ifb.active_o; ds = ifb.in_delay_slot_o;
                 mis = ifb.misaligned_o; epc = ifb.epc_o; bd = ifb.epc_bd_o; end
        default: begin pc = {16'h0, ifc.pc_o}; act = ifc.active_o; ds = ifc.in_delay_slot_o;
                 mis = ifc.misaligned_o; epc = {16'h0, ifc.epc_o}; bd = ifc.epc_bd_o; end
      endcase
      checks++;
      if (pc !== e.pc || act !== e.act || ds !== e.ds || mis !== e.mis ||
          epc !== e.epc || bd !== e.bd) begin
        errors++;
        $display("FAIL %s: got pc=%h act=%b ds=%b mis=%b epc=%h bd=%b, want pc=%h act=%b ds=%b mis=%b epc=%h bd=%b",
                 e.name, pc, act, ds, mis, epc, bd, e.pc, e.act, e.ds, e.mis, e.epc, e.bd);
      end
    end
  end

  task automatic expect_state(input int d, input logic [31:0] pc, input logic act, input logic ds,
                              input logic [31:0] epc, input logic bd, input string nm);
    exp_t e;
    e.dut = d; e.pc = pc; e.act = act; e.ds = ds; e.mis = (pc[1:0] != 2'b00);
    e.epc = epc; e.bd = bd; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic clear_inputs();
    ifa.advance = 0; ifa.branch_valid = 0; ifa.branch_target = '0; ifa.exc_req = 0;
    ifb.advance = 0; ifb.branch_valid = 0; ifb.branch_target = '0; ifb.exc_req = 0;
    ifc.advance = 0; ifc.branch_valid = 0; ifc.branch_target = '0; ifc.exc_req = 0;
  endtask

  // One posedge of stimulus on DUT d, then queue the state expected after it.
  task automatic step(input int d, input logic adv, input logic br, input logic [31:0] tgt,
                      input logic exc, input logic [31:0] pc, input logic act, input logic ds,
                      input logic [31:0] epc, input logic bd, input string nm);
    @(negedge clk); #1;
    clear_inputs();
    case (d)
      0: begin ifa.advance = adv; ifa.branch_valid = br; ifa.branch_target = tgt; ifa.exc_req = exc; end
      1: begin ifb.advance = adv; ifb.branch_valid = br; ifb.branch_target = tgt; ifb.exc_req = exc; end
      default: begin ifc.advance = adv; ifc.branch_valid = br; ifc.branch_target = tgt[15:0]; ifc.exc_req = exc; end
    endcase
    @(posedge clk); #1;
    clear_inputs();
    expect_state(d, pc, act, ds, epc, bd, nm);
  endtask

  // Reset asserted between edges; the reset value must appear before the next edge.
  task automatic mid_reset(input int d, input logic [31:0] rv, input string nm);
    @(posedge clk); #2;
    clear_inputs();
    reset_n = 0;
    #1 expect_state(d, rv, 1'b1, 1'b0, 32'h0, 1'b0, nm);
    @(negedge clk); #1;
    reset_n = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    clear_inputs();
    reset_n = 0;
    #2;
    expect_state(0, 32'hBFC00000, 1, 0, 32'h0, 0, "a_reset");
    expect_state(1, 32'hBFC00000, 1, 0, 32'h0, 0, "b_reset");
    expect_state(2, 32'h0000FFF8, 1, 0, 32'h0, 0, "c_reset");
    @(negedge clk); #1;
    reset_n = 1;

    // DUT A: sequential, mid-clock reset, delay-slot branch
    step(0, 1, 0, 0, 0, 32'hBFC00004, 1, 0, 0, 0, "a_seq1");
    step(0, 1, 0, 0, 0, 32'hBFC00008, 1, 0, 0, 0, "a_seq2");
    step(0, 1, 0, 0, 0, 32'hBFC0000C, 1, 0, 0, 0, "a_seq3");
    mid_reset(0, 32'hBFC00000, "a_midreset");
    for (int i = 1; i <= 4; i++)
      step(0, 1, 0, 0, 0, 32'hBFC00000 + 32'(4 * i), 1, 0, 0, 0, "a_run");
    step(0, 1, 1, 32'hBFC00100, 0, 32'hBFC00014, 1, 1, 0, 0, "a_br_slot");
    step(0, 1, 1, 32'hBFC00200, 0, 32'hBFC00100, 1, 0, 0, 0, "a_br_target");
    step(0, 0, 1, 32'h00000000, 0, 32'hBFC00100, 1, 0, 0, 0, "a_noadv_hold");

    // DUT A: exception in delay slot, exception beats advance, exception in RUN
    mid_reset(0, 32'hBFC00000, "a_reset2");
    for (int i = 1; i <= 4; i++)
      step(0, 1, 0, 0, 0, 32'hBFC00000 + 32'(4 * i), 1, 0, 0, 0, "a_run2");
    step(0, 1, 1, 32'hBFC00100, 0, 32'hBFC00014, 1, 1, 0, 0, "a_br_slot2");
    step(0, 0, 0, 0, 0, 32'hBFC00014, 1, 1, 0, 0, "a_slot_hold");
    step(0, 0, 0, 0, 1, 32'hBFC00380, 1, 0, 32'hBFC00010, 1, "a_exc_slot");
    step(0, 1, 0, 0, 0, 32'hBFC00384, 1, 0, 32'hBFC00010, 1, "a_after_exc");
    step(0, 1, 0, 0, 1, 32'hBFC00380, 1, 0, 32'hBFC00384, 0, "a_exc_vs_adv");
    mid_reset(0, 32'hBFC00000, "a_reset3");
    for (int i = 1; i <= 8; i++)
      step(0, 1, 0, 0, 0, 32'hBFC00000 + 32'(4 * i), 1, 0, 0, 0, "a_run3");
    step(0, 0, 0, 0, 1, 32'hBFC00380, 1, 0, 32'hBFC00020, 0, "a_exc_run");

    // DUT A: jump to zero halts after the delay slot
    step(0, 1, 1, 32'h0, 0, 32'hBFC00384, 1, 1, 32'hBFC00020, 0, "a_jz_slot");
    step(0, 1, 0, 0, 0, 32'h00000000, 0, 0, 32'hBFC00020, 0, "a_halt");
    step(0, 1, 0, 0, 0, 32'h00000000, 0, 0, 32'hBFC00020, 0, "a_halt_adv");
    step(0, 0, 0, 0, 1, 32'h00000000, 0, 0, 32'hBFC00020, 0, "a_halt_exc");
    step(0, 1, 1, 32'hBFC00100, 0, 32'h00000000, 0, 0, 32'hBFC00020, 0, "a_halt_br");
    mid_reset(0, 32'hBFC00000, "a_halt_reset");

    // DUT B: no delay slot
    for (int i = 1; i <= 4; i++)
      step(1, 1, 0, 0, 0, 32'hBFC00000 + 32'(4 * i), 1, 0, 0, 0, "b_run");
    step(1, 1, 1, 32'hBFC00100, 0, 32'hBFC00100, 1, 0, 0, 0, "b_br_direct");
    step(1, 1, 0, 0, 0, 32'hBFC00104, 1, 0, 0, 0, "b_after_br");
    step(1, 0, 0, 0, 1, 32'hBFC00380, 1, 0, 32'hBFC00104, 0, "b_exc_run");

    // DUT C: 16-bit wrap to zero halts; misaligned target is loaded and flagged
    mid_reset(2, 32'h0000FFF8, "c_reset2");
    step(2, 1, 0, 0, 0, 32'h0000FFFC, 1, 0, 0, 0, "c_seq");
    step(2, 1, 0, 0, 0, 32'h00000000, 0, 0, 0, 0, "c_wrap_halt");
    step(2, 1, 0, 0, 0, 32'h00000000, 0, 0, 0, 0, "c_halt_hold");
    mid_reset(2, 32'h0000FFF8, "c_reset3");
    step(2, 1, 1, 32'h00000102, 0, 32'h0000FFFC, 1, 1, 0, 0, "c_br_slot");
    step(2, 1, 0, 0, 0, 32'h00000102, 1, 0, 0, 0, "c_misaligned");
    step(2, 1, 0, 0, 0, 32'h00000106, 1, 0, 0, 0, "c_misaligned_seq");

    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
